// File: rtl/a2d_pkg.sv
// Shared types, SPI timing constants and command-word helper for the A2D
// conversion front end.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TXN1,
    GAP,
    TXN2,
    DONE
  } a2d_state_t;

  localparam logic [4:0] SCLK_PRELOAD = 5'b10111;
  localparam logic [4:0] SMPL_PT      = 5'b01111;
  localparam logic [4:0] SHFT_PT      = 5'b11111;
  localparam int         GAP_CYCLES   = 32;
  localparam logic [4:0] GAP_LAST     = 5'(GAP_CYCLES - 1);
  localparam logic [4:0] BITS_PER_TXN = 5'd16;

  function automatic logic [15:0] build_cmd(input logic [2:0] chnnl);
    return {2'b00, chnnl, 11'h000};
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master: SCLK is clk/32 and idles high, MISO is sampled just before
// each SCLK rise and MOSI changes on SCLK falls.
module spi_mstr16
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  logic        ss_n_q, ss_n_d;
  logic [4:0]  sclk_div_q, sclk_div_d, sclk_div_inc;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_q     <= 1'b1;
      sclk_div_q <= SHFT_PT;
      bit_cnt_q  <= 5'd0;
      tx_q       <= 16'h0000;
      rx_q       <= 16'h0000;
    end else begin
      ss_n_q     <= ss_n_d;
      sclk_div_q <= sclk_div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
    end
  end

  always_comb begin
    ss_n_d       = ss_n_q;
    sclk_div_d   = sclk_div_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    done         = 1'b0;
    sclk_div_inc = sclk_div_q + 5'd1;

    if (wrt) begin
      ss_n_d     = 1'b0;
      sclk_div_d = SCLK_PRELOAD;
      bit_cnt_d  = 5'd0;
      tx_d       = cmd;
    end else if (!ss_n_q) begin
      sclk_div_d = sclk_div_inc;
      if (sclk_div_q == SMPL_PT) begin
        rx_d      = {rx_q[14:0], MISO};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
      // No sample yet means this is the first fall: the MSB is already on MOSI
      if ((sclk_div_q == SHFT_PT) && (bit_cnt_q != 5'd0)) begin
        tx_d = {tx_q[14:0], 1'b0};
      end
      if ((bit_cnt_q == BITS_PER_TXN) && (sclk_div_inc == SHFT_PT)) begin
        ss_n_d = 1'b1;
        done   = 1'b1;
      end
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_div_q[4];
  assign MOSI    = tx_q[15];
  assign rd_data = rx_q;

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion front end: one start_conv pulse runs a command transaction, a
// guard gap, then a second transaction whose low 12 bits become the result.
module a2d_intf
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_conv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        cnv_cmplt,
  output logic [11:0] res
);

  a2d_state_t  state_q, state_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic [4:0]  gap_cnt_q, gap_cnt_d;
  logic [11:0] res_q, res_d;
  logic        cnv_cmplt_q, cnv_cmplt_d;

  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] rd_data;
  logic        unused_rd_upper;

  spi_mstr16 u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (spi_wrt),
    .cmd     (spi_cmd),
    .MISO    (MISO),
    .done    (spi_done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chnnl_q     <= 3'd0;
      gap_cnt_q   <= 5'd0;
      res_q       <= 12'h000;
      cnv_cmplt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chnnl_q     <= chnnl_d;
      gap_cnt_q   <= gap_cnt_d;
      res_q       <= res_d;
      cnv_cmplt_q <= cnv_cmplt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chnnl_d     = chnnl_q;
    gap_cnt_d   = gap_cnt_q;
    res_d       = res_q;
    cnv_cmplt_d = cnv_cmplt_q;
    spi_wrt     = 1'b0;
    spi_cmd     = build_cmd(chnnl_q);

    case (state_q)
      IDLE: begin
        if (start_conv) begin
          chnnl_d     = chnnl;
          spi_cmd     = build_cmd(chnnl);
          spi_wrt     = 1'b1;
          cnv_cmplt_d = 1'b0;
          state_d     = TXN1;
        end
      end
      TXN1: begin
        if (spi_done) begin
          gap_cnt_d = 5'd0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          spi_wrt = 1'b1;
          state_d = TXN2;
        end else begin
          gap_cnt_d = gap_cnt_q + 5'd1;
        end
      end
      TXN2: begin
        if (spi_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res_d       = rd_data[11:0];
        cnv_cmplt_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The A2D returns four don't-care bits above the 12-bit reading
  assign unused_rd_upper = ^rd_data[15:12];

  assign cnv_cmplt = cnv_cmplt_q;
  assign res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: a timeline model of one conversion plus an A2D slave model,
// compared against the DUT outputs every cycle, with literal timing pins.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_conv = 1'b0;
  logic [2:0]  chnnl = 3'd0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, cnv_cmplt;
  logic [11:0] res;

  int checks = 0;
  int failures = 0;

  logic [15:0] w1_next = 16'h0000;
  logic [15:0] w2_next = 16'h0000;

  logic        s_rst = 1'b1;
  logic        s_start = 1'b0;
  logic [2:0]  s_chnnl = 3'd0;

  bit          checking = 1'b0;
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_cmd = 16'h0000;
  logic [15:0] m_w1 = 16'h0000;
  logic [15:0] m_w2 = 16'h0000;
  logic        exp_cmplt = 1'b0;
  logic [11:0] exp_res = 12'h000;

  logic        sl_prev_sclk = 1'b1;
  int          sl_rises = 0;
  logic [15:0] sl_mosi = 16'h0000;

  a2d_intf dut (
    .clk        (clk),
    .rst        (rst),
    .start_conv (start_conv),
    .chnnl      (chnnl),
    .MISO       (MISO),
    .SS_n       (SS_n),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .cnv_cmplt  (cnv_cmplt),
    .res        (res)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    s_rst   <= rst;
    s_start <= start_conv;
    s_chnnl <= chnnl;
  end

  // Model: k counts cycles since the accepted pulse; SS_n is low for cycles
  // 1..520 and 553..1072, the result appears in cycle 1074.
  always @(negedge clk) begin
    bit          prev_active;
    bit          in_txn;
    int          u;
    int          idx;
    logic        exp_ss, exp_sclk, exp_mosi;
    logic [15:0] word;

    if (s_rst) begin
      m_active  = 1'b0;
      m_k       = 0;
      exp_cmplt = 1'b0;
      exp_res   = 12'h000;
    end else begin
      prev_active = m_active;
      if (m_active) begin
        m_k++;
        if (m_k == 1074) begin
          exp_cmplt = 1'b1;
          exp_res   = m_w2[11:0];
          m_active  = 1'b0;
        end
      end
      if (s_start && !prev_active) begin
        m_active  = 1'b1;
        m_k       = 1;
        exp_cmplt = 1'b0;
        m_cmd     = {2'b00, s_chnnl, 11'h000};
        m_w1      = w1_next;
        m_w2      = w2_next;
      end
    end

    in_txn = 1'b0;
    u      = 0;
    word   = 16'h0000;
    if (m_active && m_k >= 1 && m_k <= 520) begin
      in_txn = 1'b1;
      u      = m_k - 1;
      word   = m_w1;
    end else if (m_active && m_k >= 553 && m_k <= 1072) begin
      in_txn = 1'b1;
      u      = m_k - 553;
      word   = m_w2;
    end
    idx      = (u < 9) ? 15 : 15 - (u - 9) / 32;
    exp_ss   = !in_txn;
    exp_sclk = in_txn ? !((u >= 9) && (((u - 9) % 32) < 16)) : 1'b1;
    exp_mosi = in_txn ? m_cmd[idx] : 1'b0;

    if (checking) begin
      checkOutput("ss_n", {31'd0, SS_n}, {31'd0, exp_ss});
      checkOutput("sclk", {31'd0, SCLK}, {31'd0, exp_sclk});
      checkOutput("mosi", {31'd0, MOSI}, {31'd0, exp_mosi});
      checkOutput("cnv_cmplt", {31'd0, cnv_cmplt}, {31'd0, exp_cmplt});
      checkOutput("res", {20'd0, res}, {20'd0, exp_res});
      if (m_active && (m_k == 521 || m_k == 1073)) begin
        checkOutput("sclk_rises", sl_rises, 16);
        checkOutput("mosi_word", {16'd0, sl_mosi}, {16'd0, m_cmd});
      end
    end

    // A2D slave: presents its word MSB first, advancing after each SCLK rise
    if (SS_n !== 1'b0) begin
      sl_rises = 0;
      sl_mosi  = 16'h0000;
      MISO     = 1'b0;
    end else begin
      if (SCLK === 1'b1 && sl_prev_sclk === 1'b0) begin
        sl_rises++;
        sl_mosi = {sl_mosi[14:0], MOSI};
      end
      MISO = (sl_rises < 16) ? word[15 - sl_rises] : 1'b0;
    end
    sl_prev_sclk = SCLK;
  end

  // Caller sits on a negedge; the pulse occupies that cycle (N) and the task
  // returns on the negedge of cycle N+1074.
  task automatic applyStimulus(input logic [2:0] ch, input logic [15:0] w1, input logic [15:0] w2,
                               input logic [15:0] exp_cmd, input logic [11:0] exp_result, input bit repulse);
    w1_next    = w1;
    w2_next    = w2;
    chnnl      = ch;
    start_conv = 1'b1;
    for (int c = 1; c <= 1074; c++) begin
      @(negedge clk);
      start_conv = repulse && (c == 300 || c == 1073);
      if (c == 1) chnnl = 3'($urandom);
      case (c)
        1: begin
          checkOutput("lit_ss_fall", {31'd0, SS_n}, 32'd0);
          checkOutput("lit_cmplt_clear", {31'd0, cnv_cmplt}, 32'd0);
        end
        9:    checkOutput("lit_sclk_pre_fall", {31'd0, SCLK}, 32'd1);
        10:   checkOutput("lit_sclk_first_fall", {31'd0, SCLK}, 32'd0);
        26:   checkOutput("lit_sclk_first_rise", {31'd0, SCLK}, 32'd1);
        520: begin
          checkOutput("lit_ss_txn1_last", {31'd0, SS_n}, 32'd0);
          checkOutput("lit_cmd_word", {16'd0, sl_mosi}, {16'd0, exp_cmd});
          checkOutput("lit_cmd_chnnl", {29'd0, sl_mosi[13:11]}, {29'd0, ch});
        end
        521:  checkOutput("lit_ss_txn1_rise", {31'd0, SS_n}, 32'd1);
        552:  checkOutput("lit_ss_gap_end", {31'd0, SS_n}, 32'd1);
        553:  checkOutput("lit_ss_txn2_fall", {31'd0, SS_n}, 32'd0);
        1072: checkOutput("lit_ss_txn2_last", {31'd0, SS_n}, 32'd0);
        1073: begin
          checkOutput("lit_ss_txn2_rise", {31'd0, SS_n}, 32'd1);
          checkOutput("lit_cmplt_pre_done", {31'd0, cnv_cmplt}, 32'd0);
        end
        1074: begin
          checkOutput("lit_cmplt_done", {31'd0, cnv_cmplt}, 32'd1);
          checkOutput("lit_res", {20'd0, res}, {20'd0, exp_result});
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyResetMidTxn(input logic [2:0] ch);
    w1_next    = 16'($urandom);
    w2_next    = 16'($urandom);
    chnnl      = ch;
    start_conv = 1'b1;
    for (int c = 1; c <= 1900; c++) begin
      @(negedge clk);
      start_conv = 1'b0;
      rst        = (c == 700);
      if (c == 701) begin
        checkOutput("lit_rst_ss_n", {31'd0, SS_n}, 32'd1);
        checkOutput("lit_rst_sclk", {31'd0, SCLK}, 32'd1);
        checkOutput("lit_rst_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        checkOutput("lit_rst_res", {20'd0, res}, 32'd0);
      end
      if (c == 1900) checkOutput("lit_no_result_after_rst", {31'd0, cnv_cmplt}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] w2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    rst      = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 0) begin
        checkOutput("lit_idle_ss_n", {31'd0, SS_n}, 32'd1);
        checkOutput("lit_idle_sclk", {31'd0, SCLK}, 32'd1);
        checkOutput("lit_idle_mosi", {31'd0, MOSI}, 32'd0);
        checkOutput("lit_idle_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        checkOutput("lit_idle_res", {20'd0, res}, 32'd0);
      end
    end

    applyStimulus(3'd4, 16'($urandom), 16'h0ABC, 16'h2000, 12'hABC, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(3'd2, 16'hF123, 16'h5555, 16'h1000, 12'h555, 1'b0);
    repeat (3) @(negedge clk);
    w2 = 16'($urandom);
    applyStimulus(3'd7, 16'($urandom), w2, 16'h3800, w2[11:0], 1'b1);
    w2 = 16'($urandom);
    applyStimulus(3'd1, 16'($urandom), w2, 16'h0800, w2[11:0], 1'b0);
    repeat (4) @(negedge clk);
    applyResetMidTxn(3'd5);

    for (int c = 0; c < 8; c++) begin
      w2 = 16'($urandom);
      applyStimulus(3'(c), 16'($urandom), w2, {2'b00, 3'(c), 11'h000}, w2[11:0], 1'b0);
      repeat (2) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
